prescaled_counter: RTL and testbench

//   Modulo-N up/down counter advanced by an internal clock-enable prescaler.
//   All logic runs on the single system clock; no derived clocks.

---
 rtl/prescaled_counter.sv | 133 +++++++++++++
 tb/tb_prescaled_counter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prescaled_counter.sv
// -----------------------------------------------------------------------------
// prescaled_counter
//   Modulo-MODULO up/down counter that advances once every DIV clock cycles.
//   An internal prescaler generates a clock-enable step, so everything runs on
//   the single system clock. The tick and tc pulses let counter stages be
//   chained, for example seconds into minutes on a display.
//
// Parameters
//   WIDTH    counter width in bits
//   MODULO   count range 0..MODULO-1, 2 <= MODULO <= 2**WIDTH
//   DIV      clk cycles per counter step, DIV >= 1
//
// Ports
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   en        in   1 = prescaler runs, 0 = prescaler and count hold
//   up_dn     in   1 = count up, 0 = count down (sampled on a step cycle)
//   clr       in   synchronous clear of the count and the prescaler
//   load      in   synchronous load of load_val (saturated to MODULO-1)
//   load_val  in   load value
//   count     out  current count, registered
//   tick      out  one-cycle pulse at each count step
//   tc        out  one-cycle pulse at each wrap (terminal count)
// -----------------------------------------------------------------------------
module prescaled_counter #(
    parameter int WIDTH  = 4,
    parameter int MODULO = 16,
    parameter int DIV    = 25000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             tc
);

    // A prescaler width of at least 1 keeps DIV=1 legal. With DIV=1 the
    // register then sits at 0 and every enabled cycle is a step.
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [PW-1:0]    PRE_LAST = PW'(DIV - 1);
    localparam logic [WIDTH-1:0] CNT_MAX  = WIDTH'(MODULO - 1);
    // The limit is one bit wider so that MODULO = 2**WIDTH still fits.
    localparam logic [WIDTH:0]   MOD_EXT  = (WIDTH + 1)'(MODULO);

    logic [PW-1:0]    pre_q,   pre_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tick_q,  tick_d;
    logic             tc_q,    tc_d;
    logic             step_s;
    logic [PW-1:0]    pre_run_s;

    // Step condition and the free-running prescaler value that ignores clr.
    always_comb begin
        step_s    = en && (pre_q == PRE_LAST);
        pre_run_s = pre_q;
        if (step_s) begin
            pre_run_s = {PW{1'b0}};
        end else if (en) begin
            pre_run_s = pre_q + {{(PW-1){1'b0}}, 1'b1};
        end else begin
            pre_run_s = pre_q;
        end
    end

    // Next-state logic with priority clr > load > step > hold.
    always_comb begin
        pre_d   = pre_run_s;
        count_d = count_q;
        tick_d  = 1'b0;
        tc_d    = 1'b0;
        if (clr) begin
            pre_d   = {PW{1'b0}};
            count_d = {WIDTH{1'b0}};
        end else if (load) begin
            // The prescaler keeps running, so a step that coincides with a
            // load is lost and the next one keeps its original phase.
            if ({1'b0, load_val} >= MOD_EXT) begin
                count_d = CNT_MAX;
            end else begin
                count_d = load_val;
            end
        end else if (step_s) begin
            tick_d = 1'b1;
            // The wrap is detected by comparison, so a MODULO below 2**WIDTH
            // never depends on natural overflow.
            if (up_dn) begin
                if (count_q == CNT_MAX) begin
                    count_d = {WIDTH{1'b0}};
                    tc_d    = 1'b1;
                end else begin
                    count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
                    tc_d    = 1'b0;
                end
            end else begin
                if (count_q == {WIDTH{1'b0}}) begin
                    count_d = CNT_MAX;
                    tc_d    = 1'b1;
                end else begin
                    count_d = count_q - {{(WIDTH-1){1'b0}}, 1'b1};
                    tc_d    = 1'b0;
                end
            end
        end else begin
            count_d = count_q;
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q   <= {PW{1'b0}};
            count_q <= {WIDTH{1'b0}};
            tick_q  <= 1'b0;
            tc_q    <= 1'b0;
        end else begin
            pre_q   <= pre_d;
            count_q <= count_d;
            tick_q  <= tick_d;
            tc_q    <= tc_d;
        end
    end

    assign count = count_q;
    assign tick  = tick_q;
    assign tc    = tc_q;

endmodule

// File: tb/tb_prescaled_counter.sv
// -----------------------------------------------------------------------------
// tb_prescaled_counter
//   Directed test of prescaled_counter. The main instance uses DIV=4,
//   MODULO=10 and WIDTH=4. The second instance uses DIV=1, MODULO=16 and
//   WIDTH=4. Inputs change 1 ns after a rising edge, and outputs are checked
//   at the same point, so each check sees the state left by the edge before.
// -----------------------------------------------------------------------------
module tb_prescaled_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, up_dn, clr, load;
    logic [3:0] load_val;
    logic [3:0] count;
    logic       tick, tc;

    logic       en2, up2, clr2, load2;
    logic [3:0] lv2;
    logic [3:0] count2;
    logic       tick2, tc2;

    int total = 0;
    int bad   = 0;

    prescaled_counter #(.WIDTH(4), .MODULO(10), .DIV(4)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clr(clr),
        .load(load), .load_val(load_val), .count(count), .tick(tick), .tc(tc)
    );

    prescaled_counter #(.WIDTH(4), .MODULO(16), .DIV(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .en(en2), .up_dn(up2), .clr(clr2),
        .load(load2), .load_val(lv2), .count(count2), .tick(tick2), .tc(tc2)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 ns past it.
    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        edge1();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        rst_n = 1'b0; en = 1'b0; up_dn = 1'b1; clr = 1'b0; load = 1'b0;
        load_val = 4'd0;
        en2 = 1'b0; up2 = 1'b1; clr2 = 1'b0; load2 = 1'b0; lv2 = 4'd0;
        #3;
        total++;
        if (count !== 4'd0 || tick !== 1'b0 || tc !== 1'b0) begin
            bad++;
            $display("FAIL reset_init: count=%0d tick=%b tc=%b want 0/0/0", count, tick, tc);
        end
        edge1();
        rst_n = 1'b1;
        en = 1'b1;
        n = 0;
        while (tick !== 1'b1 && n < 10) begin
            edge1();
            n++;
        end
        total++;
        if (n != 4 || count !== 4'd1) begin
            bad++;
            $display("FAIL reset_run: edges=%0d count=%0d want 4/1", n, count);
        end
        // Reset between edges while tick is high.
        rst_n = 1'b0;
        #2;
        total++;
        if (count !== 4'd0 || tick !== 1'b0 || tc !== 1'b0) begin
            bad++;
            $display("FAIL reset_async: count=%0d tick=%b tc=%b want 0/0/0", count, tick, tc);
        end
        rst_n = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            edge1();
            total++;
            if (tick !== (i == 4) || count !== ((i == 4) ? 4'd1 : 4'd0)) begin
                bad++;
                $display("FAIL reset_first_tick: edge=%0d tick=%b count=%0d want %b/%0d",
                         i, tick, count, (i == 4), (i == 4) ? 1 : 0);
            end
        end
    endtask

    task automatic test_count_up();
        logic       exp_tick, exp_tc;
        logic [3:0] exp_cnt;
        up_dn = 1'b1;
        en    = 1'b1;
        do_clr();
        for (int i = 1; i <= 40; i++) begin
            edge1();
            exp_tick = (i % 4 == 0);
            exp_cnt  = 4'((i / 4) % 10);
            exp_tc   = (i == 40);
            total++;
            if (tick !== exp_tick || count !== exp_cnt || tc !== exp_tc) begin
                bad++;
                $display("FAIL count_up: edge=%0d got %0d/%b/%b want %0d/%b/%b",
                         i, count, tick, tc, exp_cnt, exp_tick, exp_tc);
            end
        end
    endtask

    task automatic test_count_down();
        logic [3:0] exp_cnt;
        up_dn   = 1'b0;
        exp_cnt = 4'd0;
        for (int i = 1; i <= 12; i++) begin
            edge1();
            if (i == 4)  exp_cnt = 4'd9;
            if (i == 8)  exp_cnt = 4'd8;
            if (i == 12) exp_cnt = 4'd7;
            total++;
            if (count !== exp_cnt || tick !== (i % 4 == 0) || tc !== (i == 4)) begin
                bad++;
                $display("FAIL count_down: edge=%0d got %0d/%b/%b want %0d/%b/%b",
                         i, count, tick, tc, exp_cnt, (i % 4 == 0), (i == 4));
            end
        end
        up_dn = 1'b1;
    endtask

    task automatic test_load();
        do_clr();
        for (int i = 1; i <= 3; i++) edge1();
        // The fourth edge is a step cycle and load wins over it.
        load = 1'b1; load_val = 4'd7;
        edge1();
        load = 1'b0;
        total++;
        if (count !== 4'd7 || tick !== 1'b0 || tc !== 1'b0) begin
            bad++;
            $display("FAIL load_on_step: got %0d/%b/%b want 7/0/0", count, tick, tc);
        end
        for (int i = 5; i <= 8; i++) begin
            edge1();
            total++;
            if (tick !== (i == 8) || count !== ((i == 8) ? 4'd8 : 4'd7)) begin
                bad++;
                $display("FAIL load_phase: edge=%0d tick=%b count=%0d want %b/%0d",
                         i, tick, count, (i == 8), (i == 8) ? 8 : 7);
            end
        end
        load = 1'b1; load_val = 4'd12;
        edge1();
        load = 1'b0;
        total++;
        if (count !== 4'd9 || tick !== 1'b0) begin
            bad++;
            $display("FAIL load_saturate: got %0d/%b want 9/0", count, tick);
        end
    endtask

    task automatic test_enable_hold();
        do_clr();
        edge1();
        edge1();
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            edge1();
            total++;
            if (count !== 4'd0 || tick !== 1'b0) begin
                bad++;
                $display("FAIL en_hold: cycle=%0d got %0d/%b want 0/0", i, count, tick);
            end
        end
        en = 1'b1;
        for (int j = 1; j <= 6; j++) begin
            edge1();
            total++;
            if (tick !== (j == 2 || j == 6) ||
                count !== ((j >= 6) ? 4'd2 : ((j >= 2) ? 4'd1 : 4'd0))) begin
                bad++;
                $display("FAIL en_resume: edge=%0d tick=%b count=%0d", j, tick, count);
            end
        end
    endtask

    task automatic test_clr_priority();
        int tc_cnt;
        int tick_cnt;
        edge1();
        clr = 1'b1; load = 1'b1; load_val = 4'd5;
        edge1();
        clr = 1'b0; load = 1'b0;
        total++;
        if (count !== 4'd0 || tick !== 1'b0) begin
            bad++;
            $display("FAIL clr_over_load: got %0d/%b want 0/0", count, tick);
        end
        for (int i = 1; i <= 4; i++) begin
            edge1();
            total++;
            if (tick !== (i == 4) || count !== ((i == 4) ? 4'd1 : 4'd0)) begin
                bad++;
                $display("FAIL clr_pre: edge=%0d tick=%b count=%0d want %b", i, tick, count, (i == 4));
            end
        end
        // DIV=1, MODULO=16 instance.
        clr2 = 1'b1;
        edge1();
        clr2 = 1'b0;
        en2  = 1'b1;
        tc_cnt = 0;
        tick_cnt = 0;
        for (int i = 1; i <= 16; i++) begin
            edge1();
            if (tc2 === 1'b1) tc_cnt++;
            if (tick2 === 1'b1) tick_cnt++;
            total++;
            if (count2 !== 4'(i % 16) || tc2 !== (i == 16)) begin
                bad++;
                $display("FAIL div1_step: edge=%0d got %0d/%b want %0d/%b",
                         i, count2, tc2, i % 16, (i == 16));
            end
        end
        en2 = 1'b0;
        total++;
        if (tc_cnt != 1 || tick_cnt != 16) begin
            bad++;
            $display("FAIL div1_totals: tc=%0d tick=%0d want 1/16", tc_cnt, tick_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_count_down();
        test_load();
        test_enable_hold();
        test_clr_priority();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "time limit");
    end

endmodule
